// File: rtl/acc_requant_serializer_pkg.sv
// Shared constants and state type for the accumulator requantize/serialize slice.
package acc_requant_pkg;

    localparam int DEF_COL_BLOCK_SIZE       = 32;
    localparam int DEF_BIT_SERIAL_ACC_WIDTH = 32;
    localparam int DEF_OUT_DATA_WIDTH       = 16;
    localparam int DEF_OUT_BUS_WIDTH        = 128;
    localparam int DEF_SHIFT_WIDTH          = 5;

    localparam int LANES_PER_BEAT = DEF_OUT_BUS_WIDTH / DEF_OUT_DATA_WIDTH;
    localparam int NUM_BEATS      = DEF_COL_BLOCK_SIZE / LANES_PER_BEAT;
    localparam int BEAT_CNT_WIDTH = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int SAT_MAX        = (2 ** (DEF_OUT_DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN        = -(2 ** (DEF_OUT_DATA_WIDTH - 1));

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/acc_requant_serializer_if.sv
// Input-word and output-beat handshake bundle; master is the environment, slave is the block.
interface acc_requant_serializer_if #(
    parameter int COL_BLOCK_SIZE       = 32,
    parameter int BIT_SERIAL_ACC_WIDTH = 32,
    parameter int OUT_DATA_WIDTH       = 16,
    parameter int OUT_BUS_WIDTH        = 128,
    parameter int SHIFT_WIDTH          = 5
);

    logic [BIT_SERIAL_ACC_WIDTH*COL_BLOCK_SIZE-1:0] bit_serial_acc;
    logic                                           bit_serial_acc_vld;
    logic                                           bit_serial_acc_rdy;
    logic [SHIFT_WIDTH-1:0]                         cfg_shift;
    logic                                           cfg_relu;
    logic [OUT_BUS_WIDTH-1:0]                       out_data;
    logic                                           out_vld;
    logic                                           out_rdy;
    logic                                           out_last;
    logic                                           out_sat;

    modport master (
        output bit_serial_acc, bit_serial_acc_vld, cfg_shift, cfg_relu, out_rdy,
        input  bit_serial_acc_rdy, out_data, out_vld, out_last, out_sat
    );

    modport slave (
        input  bit_serial_acc, bit_serial_acc_vld, cfg_shift, cfg_relu, out_rdy,
        output bit_serial_acc_rdy, out_data, out_vld, out_last, out_sat
    );

endinterface

// File: rtl/acc_requant_serializer_requant_lane.sv
// One accumulator lane: optional ReLU, round-half-up arithmetic right shift, signed saturation.
module requant_lane #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 5
) (
    input  logic [IN_W-1:0]    lane_in,
    input  logic               relu,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   lane_out,
    output logic               lane_sat
);

    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2 ** (OUT_W - 1)));

    logic signed [IN_W:0] x;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] y;

    always_comb begin
        x = {lane_in[IN_W-1], lane_in};
        if (relu && lane_in[IN_W-1]) begin
            x = '0;
        end
        // rnd = 2^(shift-1), which is zero for shift==0 so no separate bypass is needed
        rnd = ((IN_W+1)'(1) << shift) >> 1;
        y   = (x + rnd) >>> shift;

        lane_sat = 1'b0;
        lane_out = y[OUT_W-1:0];
        if (y > MAXV) begin
            lane_out = MAXV[OUT_W-1:0];
            lane_sat = 1'b1;
        end else if (y < MINV) begin
            lane_out = MINV[OUT_W-1:0];
            lane_sat = 1'b1;
        end
    end

endmodule

// File: rtl/acc_requant_serializer.sv
// Requantizes a wide accumulator word into a buffer and streams it out as narrow beats.
module acc_requant_serializer
    import acc_requant_pkg::*;
#(
    parameter int COL_BLOCK_SIZE       = DEF_COL_BLOCK_SIZE,
    parameter int BIT_SERIAL_ACC_WIDTH = DEF_BIT_SERIAL_ACC_WIDTH,
    parameter int OUT_DATA_WIDTH       = DEF_OUT_DATA_WIDTH,
    parameter int OUT_BUS_WIDTH        = DEF_OUT_BUS_WIDTH,
    parameter int SHIFT_WIDTH          = DEF_SHIFT_WIDTH
) (
    input logic                    clk,
    input logic                    rst_n,
    acc_requant_serializer_if.slave bus
);

    localparam int LPB = OUT_BUS_WIDTH / OUT_DATA_WIDTH;
    localparam int NB  = COL_BLOCK_SIZE / LPB;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    state_t                                   state, state_nxt;
    logic [BW-1:0]                            beat, beat_nxt;
    logic [COL_BLOCK_SIZE*OUT_DATA_WIDTH-1:0] lane_val, res_q;
    logic [COL_BLOCK_SIZE-1:0]                lane_sat, sat_q;
    logic [OUT_BUS_WIDTH-1:0]                 beat_data [NB];
    logic [NB-1:0]                            beat_sat;
    logic                                     acc_rdy, accept, on_last;
    logic [OUT_BUS_WIDTH-1:0]                 data_o;
    logic                                     vld_o, last_o, sat_o;

    for (genvar i = 0; i < COL_BLOCK_SIZE; i++) begin : g_lane
        requant_lane #(
            .IN_W    (BIT_SERIAL_ACC_WIDTH),
            .OUT_W   (OUT_DATA_WIDTH),
            .SHIFT_W (SHIFT_WIDTH)
        ) u_lane (
            .lane_in  (bus.bit_serial_acc[i*BIT_SERIAL_ACC_WIDTH +: BIT_SERIAL_ACC_WIDTH]),
            .relu     (bus.cfg_relu),
            .shift    (bus.cfg_shift),
            .lane_out (lane_val[i*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]),
            .lane_sat (lane_sat[i])
        );
    end

    for (genvar b = 0; b < NB; b++) begin : g_beat
        assign beat_data[b] = res_q[b*OUT_BUS_WIDTH +: OUT_BUS_WIDTH];
        assign beat_sat[b]  = |sat_q[b*LPB +: LPB];
    end

    // Ready reopens during the final beat's handshake so the next word follows without a bubble
    assign on_last = (state == SEND) && (beat == LAST_BEAT);
    assign acc_rdy = (state == IDLE) || (on_last && bus.out_rdy);
    assign accept  = bus.bit_serial_acc_vld && acc_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
            res_q <= '0;
            sat_q <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            if (accept) begin
                res_q <= lane_val;
                sat_q <= lane_sat;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        vld_o     = 1'b0;
        last_o    = 1'b0;
        sat_o     = 1'b0;
        data_o    = '0;
        unique case (state)
            IDLE: begin
                if (bus.bit_serial_acc_vld) begin
                    state_nxt = SEND;
                    beat_nxt  = '0;
                end
            end
            SEND: begin
                vld_o  = 1'b1;
                last_o = on_last;
                sat_o  = beat_sat[beat];
                data_o = beat_data[beat];
                if (bus.out_rdy) begin
                    if (on_last) begin
                        beat_nxt  = '0;
                        state_nxt = bus.bit_serial_acc_vld ? SEND : IDLE;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
        endcase
    end

    assign bus.bit_serial_acc_rdy = acc_rdy;
    assign bus.out_vld            = vld_o;
    assign bus.out_last           = last_o;
    assign bus.out_sat            = sat_o;
    assign bus.out_data           = data_o;

endmodule

// File: doc/acc_requant_serializer.md
Name: acc_requant_serializer

Overview:
- Downstream consumer of the accumulation stage.
- Accepts one wide word of COL_BLOCK_SIZE signed bit-serial accumulator results per handshake.
- Requantizes each lane to OUT_DATA_WIDTH: optional ReLU, rounding arithmetic right shift, then saturation.
- Streams the packed result as NUM_BEATS narrow beats toward the output buffer, with valid/ready flow control and a last marker.

Parameters:
- COL_BLOCK_SIZE, 32, number of accumulator lanes per input word
- BIT_SERIAL_ACC_WIDTH, 32, signed width of each input lane
- OUT_DATA_WIDTH, 16, signed width of each requantized lane
- OUT_BUS_WIDTH, 128, output beat width; COL_BLOCK_SIZE*OUT_DATA_WIDTH must be an integer multiple of it
- SHIFT_WIDTH, 5, width of the right-shift amount

Ports:
- clk  input  1  clock, all logic on the rising edge
- rst_n  input  1  reset; synchronous, active-low
- bit_serial_acc  input  BIT_SERIAL_ACC_WIDTH*COL_BLOCK_SIZE  lane i at bits [i*BIT_SERIAL_ACC_WIDTH +: BIT_SERIAL_ACC_WIDTH]
- bit_serial_acc_vld  input  1  input word valid
- bit_serial_acc_rdy  output  1  block can accept an input word
- cfg_shift  input  SHIFT_WIDTH  right-shift amount, sampled on input accept
- cfg_relu  input  1  clamp negative lanes to 0, sampled on input accept
- out_data  output  OUT_BUS_WIDTH  packed requantized lanes
- out_vld  output  1  beat valid
- out_rdy  input  1  downstream ready
- out_last  output  1  high on the final beat of a word
- out_sat  output  1  at least one lane in the current beat saturated

Behaviour:
- Derived values: LANES_PER_BEAT = OUT_BUS_WIDTH/OUT_DATA_WIDTH; NUM_BEATS = COL_BLOCK_SIZE/LANES_PER_BEAT (defaults 8 and 4).
- Reset (rst_n low at a clock edge):
  - state IDLE, beat counter 0
  - out_vld=0, out_last=0, out_sat=0, out_data=0
  - result buffer and saturation flags cleared
- Reset mid-transfer: remaining beats are discarded; no partial word is resumed.
- States and transitions:
  - IDLE: bit_serial_acc_rdy=1; vld&&rdy -> SEND.
  - SEND: out_vld=1; on out_vld&&out_rdy the beat counter increments.
  - On the handshake of beat NUM_BEATS-1: -> IDLE, unless a new word is accepted in the same cycle, in which case stay in SEND at beat 0.
- bit_serial_acc_rdy = (state==IDLE) || (state==SEND && beat==NUM_BEATS-1 && out_rdy). This combinational path from out_rdy is permitted and gives back-to-back words with no bubble.
- Accept cycle:
  - All lanes are requantized combinationally and registered into a COL_BLOCK_SIZE x OUT_DATA_WIDTH buffer, plus per-lane saturation flags.
  - cfg_shift and cfg_relu are used only in this cycle.
- Latency: accept at edge T; beat 0 is presented with out_vld=1 after edge T; one beat per out_rdy cycle thereafter.
- Per-lane arithmetic, in order:
  1. x = signed lane. If cfg_relu and x<0, then x=0.
  2. If s=cfg_shift>0: y = (x + 2^(s-1)) >>> s, computed at BIT_SERIAL_ACC_WIDTH+1 bits so it cannot overflow. If s=0: y=x.
  3. Saturate y to [-2^(OUT_DATA_WIDTH-1), 2^(OUT_DATA_WIDTH-1)-1]; lane sat flag = clipped.
- Beat k packing:
  - out_data carries lanes k*LANES_PER_BEAT .. k*LANES_PER_BEAT+LANES_PER_BEAT-1, lowest lane in the LSBs.
  - out_sat = OR of those lanes' sat flags.
  - out_last = (k==NUM_BEATS-1).
- While out_vld && !out_rdy: out_data, out_sat and out_last hold stable.
- Input data is ignored when bit_serial_acc_rdy=0; the upstream holds it.

Decomposition:
- Shared package (acc_requant_pkg):
  - derived constants LANES_PER_BEAT, NUM_BEATS, SAT_MAX, SAT_MIN
  - state encoding IDLE/SEND
  - beat counter width $clog2(NUM_BEATS)
- Sub-module requant_lane: one lane of ReLU, rounding shift and saturation, producing value and sat flag. Purely combinational; instantiated COL_BLOCK_SIZE times in a generate loop.
- Top: FSM, beat counter, result buffer and beat mux.

Test Plan:
- Reset then idle: after rst_n held low 2 cycles, out_vld=0, out_data=0, bit_serial_acc_rdy=1.
- Lane i=i, shift=0, relu=0, out_rdy=1 -> 4 consecutive beats; beat0 lanes 0..7 = 0..7; out_last only on beat 3; out_sat=0.
- Lane0=0x0000_0180 (384), lane1=-384, lane2=0x7FFF_FFFF, shift=4 -> lane0=24, lane1=-24, lane2=32767 with out_sat=1 on beat 0. Lane0=23, shift=1 -> 12 (round half up).
- relu=1, lane0=-1000, lane1=1000, shift=0 -> lane0=0 with no sat, lane1=1000.
- Backpressure: out_rdy low for 3 cycles on beat 2 -> out_data and out_last held constant; bit_serial_acc_rdy=0 throughout.
- Back-to-back: second word valid while beat 3 handshakes -> accepted that cycle, and its beat 0 follows immediately with no idle cycle.
- Reset during beat 1 -> out_vld=0 next cycle; following word starts at beat 0.
